oam_dma_ctrl: RTL

OAM DMA engine behind the 0xFF46 DMA register. A CPU write of byte XX copies 160 bytes from XX00–XX9F into OAM at FE00–FE9F through the MMU's DMA bus-master port. Each byte is a read cycle followed by a write cycle. While the engine owns the bus, the MMU blocks CPU access to OAM and gives the DMA master priority on every shared memory.

---
 rtl/oam_dma_ctrl_if.sv | 22 ++
 rtl/oam_dma_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl_if.sv
// Byte-wide memory-style port shared by the FF46 register access and the DMA bus master.
// Timing contract: addr_select/write_value/write_enable are qualified by write_enable alone; read_out answers addr_select.
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_value,
        output write_enable,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_value,
        input  write_enable,
        output read_out
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: a write to FF46 copies {src_hi,00..9F} into FE00..FE9F,
// one byte per BYTE_PERIOD clocks (read phase, single write cycle, optional gap).
module oam_dma_ctrl #(
    parameter int RD_LAT      = 1,
    parameter int BYTE_PERIOD = 4,
    parameter int START_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst,
    mem_if.slave       mmio_dma_if,
    mem_if.master      dma_req,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int          GAP_LEN     = BYTE_PERIOD - RD_LAT - 2;
    localparam logic [15:0] START_LAST  = 16'(START_DELAY - 1);
    localparam logic [15:0] READ_LAST   = 16'(RD_LAT);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_LEN - 1);
    localparam logic [7:0]  LAST_IDX    = 8'd159;
    localparam logic [15:0] REG_ADDR    = 16'hFF46;
    localparam logic [15:0] IDLE_ADDR   = 16'hFFFF;
    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam state_t      ENTRY_STATE = (START_DELAY > 0) ? ST_START : ST_READ;

    generate
        if (BYTE_PERIOD < RD_LAT + 2) begin : g_bad_byte_period
            $error("oam_dma_ctrl: BYTE_PERIOD must be at least RD_LAT+2");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        reg_hit;
    logic        reg_wr;
    logic        byte_end;

    assign reg_hit = (mmio_dma_if.addr_select == REG_ADDR);
    assign reg_wr  = reg_hit && mmio_dma_if.write_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            src_hi_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            src_hi_q <= src_hi_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // cnt_q counts cycles spent in the current state; every transition clears it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        data_d   = data_q;
        done_d   = 1'b0;
        byte_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_START: begin
                if (cnt_q == START_LAST) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (cnt_q == READ_LAST) begin
                    data_d  = dma_req.read_out;
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end
            end
            ST_WRITE: begin
                cnt_d = '0;
                if (GAP_LEN > 0) begin
                    state_d = ST_GAP;
                end else begin
                    byte_end = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d    = '0;
                    byte_end = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (byte_end) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 8'd1;
                state_d = ST_READ;
            end
        end

        // A register write always wins, even against completion of the last byte.
        if (reg_wr) begin
            src_hi_d = mmio_dma_if.write_value;
            state_d  = ENTRY_STATE;
            idx_d    = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
        end
    end

    // Bus outputs decode registered state only; read_out never reaches them combinationally.
    always_comb begin
        dma_req.addr_select  = IDLE_ADDR;
        dma_req.write_value  = 8'h00;
        dma_req.write_enable = 1'b0;
        case (state_q)
            ST_READ: begin
                dma_req.addr_select = {src_hi_q, idx_q};
            end
            ST_WRITE: begin
                dma_req.addr_select  = OAM_BASE + {8'h00, idx_q};
                dma_req.write_value  = data_q;
                dma_req.write_enable = 1'b1;
            end
            ST_GAP: begin
                dma_req.addr_select = OAM_BASE + {8'h00, idx_q};
            end
            default: begin
                dma_req.addr_select = IDLE_ADDR;
            end
        endcase
    end

    assign mmio_dma_if.read_out = reg_hit ? src_hi_q : 8'hFF;
    assign busy                 = (state_q != ST_IDLE);
    assign done                 = done_q;
    assign dbg_state            = state_q;

endmodule
